// File: rtl/stopwatch_timebase_display.sv
// Stopwatch timebase and display back-end: divides the reference clock into tick
// square waves and scans four BCD digits onto a common-anode 7-segment display.
module stopwatch_timebase_display #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int FAST_HZ     = 100,
  parameter int BLINK_HZ    = 4,
  parameter int SCAN_HZ     = 500
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] BLINK_EN,
  output logic       CLK_FAST,
  output logic       CLK_2HZ,
  output logic       CLK_1HZ,
  output logic       CLK_BLINK,
  output logic [6:0] dispDigit,
  output logic [3:0] selector
);

  localparam int HALF_F   = CLK_FREQ_HZ / (2 * FAST_HZ);
  localparam int HALF_2   = CLK_FREQ_HZ / 4;
  localparam int HALF_1   = CLK_FREQ_HZ / 2;
  localparam int HALF_B   = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int SCAN_CNT = CLK_FREQ_HZ / SCAN_HZ;

  // HALF_1 is the longest half-period, so it sizes every divider counter.
  localparam int CW = (HALF_1 > 1) ? $clog2(HALF_1) : 1;
  localparam int SW = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;

  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CNT - 1);
  localparam logic [6:0]    SEG_BLANK = 7'h7F;

  // Divider outputs: 0 fast, 1 2 Hz, 2 1 Hz, 3 blink.
  logic [3:0] div_out;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_div
      localparam int HALF = (gi == 0) ? HALF_F :
                            (gi == 1) ? HALF_2 :
                            (gi == 2) ? HALF_1 : HALF_B;
      localparam logic [CW-1:0] LAST = CW'(HALF - 1);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          out_q;
      logic          out_d;

      always_comb begin
        cnt_d = cnt_q + CW'(1);
        out_d = out_q;
        if (cnt_q == LAST) begin
          cnt_d = '0;
          out_d = ~out_q;
        end
      end

      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
          cnt_q <= '0;
          out_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          out_q <= out_d;
        end
      end

      assign div_out[gi] = out_q;
    end
  endgenerate

  assign CLK_FAST  = div_out[0];
  assign CLK_2HZ   = div_out[1];
  assign CLK_1HZ   = div_out[2];
  assign CLK_BLINK = div_out[3];

  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  logic [SW-1:0] scan_cnt_q;
  logic [SW-1:0] scan_cnt_d;
  logic [1:0]    idx_q;
  logic [1:0]    idx_d;
  logic [3:0]    sel_q;
  logic [3:0]    sel_d;
  logic [6:0]    seg_q;
  logic [6:0]    seg_d;
  logic [3:0]    digit_cur;
  logic [3:0][3:0] digits;

  assign digits = {d3, d2, d1, d0};
  assign digit_cur = digits[idx_q];

  // The output register samples the current idx, so the visible slot change
  // trails the idx advance by one edge and every slot lasts SCAN_CNT cycles.
  always_comb begin
    scan_cnt_d = scan_cnt_q + SW'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end
    sel_d = ~(4'b0001 << idx_q);
    seg_d = seg_decode(digit_cur);
    if (BLINK_EN[idx_q] && !div_out[3]) begin
      seg_d = SEG_BLANK;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      scan_cnt_q <= '0;
      idx_q      <= 2'd0;
      sel_q      <= 4'b1111;
      seg_q      <= SEG_BLANK;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
    end
  end

  assign selector  = sel_q;
  assign dispDigit = seg_q;

endmodule

// File: tb/tb_stopwatch_timebase_display.sv
// Directed bench for stopwatch_timebase_display: divider phases, scan order,
// decode table, blink gating and asynchronous reset.
module tb_stopwatch_timebase_display;

  localparam int HF = 2;
  localparam int H2 = 10;
  localparam int H1 = 20;
  localparam int HB = 5;
  localparam int SC = 4;

  logic       CLK;
  logic       RESET;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] BLINK_EN;
  logic       CLK_FAST, CLK_2HZ, CLK_1HZ, CLK_BLINK;
  logic [6:0] dispDigit;
  logic [3:0] selector;

  int checks = 0;
  int errors = 0;

  logic [6:0] dec_tab [16];

  typedef struct {
    logic [3:0] dig;
    logic       ben;
    logic [6:0] exp_seg;
  } vec_t;

  vec_t vecs [18];

  stopwatch_timebase_display #(
    .CLK_FREQ_HZ(40),
    .FAST_HZ    (10),
    .BLINK_HZ   (4),
    .SCAN_HZ    (10)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .d0       (d0),
    .d1       (d1),
    .d2       (d2),
    .d3       (d3),
    .BLINK_EN (BLINK_EN),
    .CLK_FAST (CLK_FAST),
    .CLK_2HZ  (CLK_2HZ),
    .CLK_1HZ  (CLK_1HZ),
    .CLK_BLINK(CLK_BLINK),
    .dispDigit(dispDigit),
    .selector (selector)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " clocks"}, {28'd0, CLK_FAST, CLK_2HZ, CLK_1HZ, CLK_BLINK}, 32'h0);
    check({tag, " selector"}, {28'd0, selector}, 32'hF);
    check({tag, " dispDigit"}, {25'd0, dispDigit}, 32'h7F);
  endtask

  // Reference model: after rising edge n (n>=1 since release) each divider
  // output equals floor(n/H) mod 2; the displayed slot is floor((n-1)/SC) mod 4
  // and the blink gate sees the divider value from edge n-1.
  task automatic run_edges(input int nedges, input string tag);
    logic [3:0] exp_clk;
    logic [3:0] exp_sel;
    logic [6:0] exp_seg;
    logic [3:0] dsel;
    int slot;
    logic blink_prev;
    for (int n = 1; n <= nedges; n++) begin
      @(negedge CLK);
      exp_clk = {1'((n / HF) % 2), 1'((n / H2) % 2), 1'((n / H1) % 2), 1'((n / HB) % 2)};
      slot = ((n - 1) / SC) % 4;
      exp_sel = ~(4'b0001 << slot);
      case (slot)
        0: dsel = d0;
        1: dsel = d1;
        2: dsel = d2;
        default: dsel = d3;
      endcase
      blink_prev = 1'(((n - 1) / HB) % 2);
      exp_seg = (BLINK_EN[slot] && !blink_prev) ? 7'h7F : dec_tab[dsel];
      check($sformatf("%s e%0d clocks", tag, n), {28'd0, CLK_FAST, CLK_2HZ, CLK_1HZ, CLK_BLINK}, {28'd0, exp_clk});
      check($sformatf("%s e%0d selector", tag, n), {28'd0, selector}, {28'd0, exp_sel});
      check($sformatf("%s e%0d dispDigit", tag, n), {25'd0, dispDigit}, {25'd0, exp_seg});
    end
  endtask

  initial begin
    dec_tab[0]  = 7'h40; dec_tab[1]  = 7'h79; dec_tab[2]  = 7'h24; dec_tab[3]  = 7'h30;
    dec_tab[4]  = 7'h19; dec_tab[5]  = 7'h12; dec_tab[6]  = 7'h02; dec_tab[7]  = 7'h78;
    dec_tab[8]  = 7'h00; dec_tab[9]  = 7'h10;
    for (int i = 10; i < 16; i++) dec_tab[i] = 7'h7F;

    for (int i = 0; i < 16; i++) begin
      vecs[i].dig     = 4'(i);
      vecs[i].ben     = 1'b0;
      vecs[i].exp_seg = dec_tab[i];
    end
    // Right after release the registered blink level is 0, so an enabled digit is blank.
    vecs[16] = '{dig: 4'd8, ben: 1'b1, exp_seg: 7'h7F};
    vecs[17] = '{dig: 4'd3, ben: 1'b1, exp_seg: 7'h7F};

    RESET = 1'b0;
    d0 = 4'd7; d1 = 4'd2; d2 = 4'd9; d3 = 4'd5;
    BLINK_EN = 4'b0000;

    repeat (3) @(negedge CLK);
    check_reset_outputs("hold reset");

    RESET = 1'b1;
    run_edges(80, "scan");

    // Asynchronous reset between edges must clear outputs immediately.
    @(negedge CLK);
    #2 RESET = 1'b0;
    #1 check_reset_outputs("async reset");

    @(negedge CLK);
    d0 = 4'd8;
    BLINK_EN = 4'b0001;
    RESET = 1'b1;
    run_edges(80, "blink");

    for (int i = 0; i < 18; i++) begin
      @(negedge CLK);
      RESET = 1'b0;
      d0 = vecs[i].dig;
      BLINK_EN = {3'b000, vecs[i].ben};
      @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      check($sformatf("vec%0d d0=%0d seg", i, vecs[i].dig), {25'd0, dispDigit}, {25'd0, vecs[i].exp_seg});
      check($sformatf("vec%0d sel", i), {28'd0, selector}, 32'hE);
    end

    // One-cycle segment latency on a change of the active digit.
    @(negedge CLK);
    RESET = 1'b0;
    d0 = 4'd3;
    BLINK_EN = 4'b0000;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check("latency before", {25'd0, dispDigit}, 32'h30);
    d0 = 4'd4;
    #1 check("latency no edge", {25'd0, dispDigit}, 32'h30);
    @(negedge CLK);
    check("latency after", {25'd0, dispDigit}, 32'h19);
    check("latency sel", {28'd0, selector}, 32'hE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
